// File: rtl/rx_drain_ctrl.sv
// rtl/rx_drain_ctrl.sv - UART receive drain sequencer with FWFT byte FIFO and saturating error counters
module rx_drain_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [7:0]               rx_data,
  input  logic                     data_ready,
  input  logic                     overrun_error,
  input  logic                     framing_error,
  output logic                     data_read,
  input  logic                     pop,
  output logic [7:0]               fifo_data,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  input  logic                     err_clear,
  output logic [CNT_W-1:0]         overrun_cnt,
  output logic [CNT_W-1:0]         framing_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_CLR = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          push;
  logic          do_pop;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic ovr_prev;
  logic frm_prev;
  logic ovr_edge;
  logic frm_edge;

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WAIT_CLR keeps a still-high data_ready from being captured twice
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (data_ready && !fifo_full) state_nxt = ACK;
      ACK:      state_nxt = WAIT_CLR;
      WAIT_CLR: if (!data_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_read = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:    push = data_ready && !fifo_full;
      ACK:     data_read = 1'b1;
      default: ;
    endcase
  end

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
  assign do_pop     = pop && !fifo_empty;
  assign fifo_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !n_rst) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign ovr_edge = overrun_error && !ovr_prev;
  assign frm_edge = framing_error && !frm_prev;

  // A clear coinciding with an edge still records that edge
  always_ff @(posedge clk) begin
    if (n_rst) begin
      ovr_prev    <= 1'b0;
      frm_prev    <= 1'b0;
      overrun_cnt <= '0;
      framing_cnt <= '0;
    end else begin
      ovr_prev <= overrun_error;
      frm_prev <= framing_error;
      if (err_clear) begin
        overrun_cnt <= ovr_edge ? CNT_W'(1) : '0;
        framing_cnt <= frm_edge ? CNT_W'(1) : '0;
      end else begin
        if (ovr_edge && overrun_cnt != CNT_MAX) overrun_cnt <= overrun_cnt + CNT_W'(1);
        if (frm_edge && framing_cnt != CNT_MAX) framing_cnt <= framing_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// tb/tb_rx_drain_ctrl.sv - self-checking bench for rx_drain_ctrl with directed scenarios and a queue-based reference model
module tb_rx_drain_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       data_read;
  logic       pop;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       err_clear;
  logic [7:0] overrun_cnt;
  logic [7:0] framing_cnt;

  int total;
  int passed;

  rx_drain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error),
    .data_read    (data_read),
    .pop          (pop),
    .fifo_data    (fifo_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .err_clear    (err_clear),
    .overrun_cnt  (overrun_cnt),
    .framing_cnt  (framing_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    rx_data       = 8'h00;
    data_ready    = 1'b0;
    pop           = 1'b0;
    overrun_error = 1'b0;
    framing_error = 1'b0;
    err_clear     = 1'b0;
  endtask

  // Receiver-style handshake: present byte, drop data_ready after the ack
  task automatic capture(input logic [7:0] b, input string tag);
    rx_data    = b;
    data_ready = 1'b1;
    tick();
    total++; if (data_read !== 1'b1) $display("FAIL %s_ack data_read=%0b exp=1", tag, data_read); else passed++;
    data_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    n_rst = 1'b1;
    tick();
    tick();
    total++; if (data_read !== 1'b0)   $display("FAIL reset_data_read got=%0b exp=0", data_read); else passed++;
    total++; if (fifo_empty !== 1'b1)  $display("FAIL reset_empty got=%0b exp=1", fifo_empty); else passed++;
    total++; if (fifo_full !== 1'b0)   $display("FAIL reset_full got=%0b exp=0", fifo_full); else passed++;
    total++; if (fifo_count !== 3'd0)  $display("FAIL reset_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (overrun_cnt !== 8'd0) $display("FAIL reset_ovr got=%0d exp=0", overrun_cnt); else passed++;
    total++; if (framing_cnt !== 8'd0) $display("FAIL reset_frm got=%0d exp=0", framing_cnt); else passed++;
    n_rst = 1'b0;
    tick();
  endtask

  task automatic test_single_byte;
    rx_data    = 8'hA5;
    data_ready = 1'b1;
    tick();
    total++; if (data_read !== 1'b1)  $display("FAIL single_ack got=%0b exp=1", data_read); else passed++;
    total++; if (fifo_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", fifo_data); else passed++;
    total++; if (fifo_count !== 3'd1) $display("FAIL single_count got=%0d exp=1", fifo_count); else passed++;
    total++; if (fifo_empty !== 1'b0) $display("FAIL single_empty got=%0b exp=0", fifo_empty); else passed++;
    tick();
    total++; if (data_read !== 1'b0)  $display("FAIL single_ack_width got=%0b exp=0", data_read); else passed++;
    data_ready = 1'b0;
    tick();
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    total++; if (fifo_empty !== 1'b1) $display("FAIL single_pop_empty got=%0b exp=1", fifo_empty); else passed++;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    total++; if (fifo_count !== 3'd0) $display("FAIL single_pop_when_empty got=%0d exp=0", fifo_count); else passed++;
  endtask

  task automatic test_fill_stall_wrap;
    for (int k = 1; k <= 4; k++) capture(8'(k), "fill");
    rx_data    = 8'h05;
    data_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (data_read !== 1'b0) $display("FAIL stall_ack cyc=%0d got=%0b exp=0", k, data_read); else passed++;
      total++; if (fifo_full !== 1'b1) $display("FAIL stall_full cyc=%0d got=%0b exp=1", k, fifo_full); else passed++;
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    total++; if (fifo_count !== 3'd3) $display("FAIL stall_pop_count got=%0d exp=3", fifo_count); else passed++;
    total++; if (fifo_data !== 8'h02) $display("FAIL stall_pop_head got=%h exp=02", fifo_data); else passed++;
    total++; if (data_read !== 1'b0)  $display("FAIL stall_pop_ack got=%0b exp=0", data_read); else passed++;
    tick();
    total++; if (data_read !== 1'b1)  $display("FAIL refill_ack got=%0b exp=1", data_read); else passed++;
    total++; if (fifo_count !== 3'd4) $display("FAIL refill_count got=%0d exp=4", fifo_count); else passed++;
    data_ready = 1'b0;
    tick();
    tick();
    for (int k = 2; k <= 5; k++) begin
      total++; if (fifo_data !== 8'(k)) $display("FAIL wrap_drain got=%h exp=%h", fifo_data, 8'(k)); else passed++;
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    total++; if (fifo_empty !== 1'b1) $display("FAIL wrap_empty got=%0b exp=1", fifo_empty); else passed++;
  endtask

  task automatic test_push_pop_same;
    capture(8'h10, "pp");
    capture(8'h11, "pp");
    rx_data    = 8'h12;
    data_ready = 1'b1;
    pop        = 1'b1;
    tick();
    pop        = 1'b0;
    total++; if (fifo_count !== 3'd2) $display("FAIL pushpop_count got=%0d exp=2", fifo_count); else passed++;
    total++; if (fifo_data !== 8'h11) $display("FAIL pushpop_head got=%h exp=11", fifo_data); else passed++;
    total++; if (data_read !== 1'b1)  $display("FAIL pushpop_ack got=%0b exp=1", data_read); else passed++;
    data_ready = 1'b0;
    tick();
    tick();
    for (int k = 8'h11; k <= 8'h12; k++) begin
      total++; if (fifo_data !== 8'(k)) $display("FAIL pushpop_drain got=%h exp=%h", fifo_data, 8'(k)); else passed++;
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    total++; if (fifo_empty !== 1'b1) $display("FAIL pushpop_empty got=%0b exp=1", fifo_empty); else passed++;
  endtask

  task automatic test_err_counters;
    overrun_error = 1'b1;
    tick();
    total++; if (overrun_cnt !== 8'd1) $display("FAIL ovr_latency got=%0d exp=1", overrun_cnt); else passed++;
    overrun_error = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      overrun_error = 1'b1; tick();
      overrun_error = 1'b0; tick();
    end
    framing_error = 1'b1;
    repeat (5) tick();
    framing_error = 1'b0;
    tick();
    total++; if (overrun_cnt !== 8'd3) $display("FAIL ovr_three got=%0d exp=3", overrun_cnt); else passed++;
    total++; if (framing_cnt !== 8'd1) $display("FAIL frm_level got=%0d exp=1", framing_cnt); else passed++;
    for (int k = 0; k < 255; k++) begin
      overrun_error = 1'b1; tick();
      overrun_error = 1'b0; tick();
    end
    total++; if (overrun_cnt !== 8'd255) $display("FAIL ovr_saturate got=%0d exp=255", overrun_cnt); else passed++;
    overrun_error = 1'b1;
    err_clear     = 1'b1;
    tick();
    err_clear     = 1'b0;
    overrun_error = 1'b0;
    total++; if (overrun_cnt !== 8'd1) $display("FAIL clear_with_edge got=%0d exp=1", overrun_cnt); else passed++;
    total++; if (framing_cnt !== 8'd0) $display("FAIL clear_frm got=%0d exp=0", framing_cnt); else passed++;
    tick();
  endtask

  task automatic test_reset_in_ack;
    rx_data    = 8'h77;
    data_ready = 1'b1;
    tick();
    total++; if (data_read !== 1'b1)  $display("FAIL rstack_pre got=%0b exp=1", data_read); else passed++;
    n_rst      = 1'b1;
    data_ready = 1'b0;
    tick();
    n_rst      = 1'b0;
    total++; if (data_read !== 1'b0)  $display("FAIL rstack_ack got=%0b exp=0", data_read); else passed++;
    total++; if (fifo_count !== 3'd0) $display("FAIL rstack_count got=%0d exp=0", fifo_count); else passed++;
    total++; if (fifo_empty !== 1'b1) $display("FAIL rstack_empty got=%0b exp=1", fifo_empty); else passed++;
    rx_data    = 8'h88;
    data_ready = 1'b1;
    tick();
    total++; if (data_read !== 1'b1)  $display("FAIL rstack_idle_ack got=%0b exp=1", data_read); else passed++;
    total++; if (fifo_data !== 8'h88) $display("FAIL rstack_idle_data got=%h exp=88", fifo_data); else passed++;
    data_ready = 1'b0;
    tick();
    tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  // Reference: a byte queue plus the rule that a new capture needs data_ready
  // to have been seen low at least two cycles after the previous capture.
  task automatic test_random;
    logic [7:0] q[$];
    logic       exp_ack;
    int         exp_ovr, exp_frm;
    logic       prev_oe, prev_fe;
    logic       seen_low;
    int         last_cap;
    logic       dr, pp, oe, fe, ec, psh, pok, e_o, e_f;
    logic [7:0] rxd;

    idle_inputs();
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    exp_ack  = 1'b0;
    exp_ovr  = 0;
    exp_frm  = 0;
    prev_oe  = 1'b0;
    prev_fe  = 1'b0;
    seen_low = 1'b1;
    last_cap = -100;

    for (int cyc = 0; cyc < 2000; cyc++) begin
      total++; if (data_read !== exp_ack) $display("FAIL rnd_ack cyc=%0d got=%0b exp=%0b", cyc, data_read, exp_ack); else passed++;
      total++; if (fifo_count !== 3'(q.size())) $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, q.size()); else passed++;
      total++; if (fifo_empty !== (q.size() == 0)) $display("FAIL rnd_empty cyc=%0d got=%0b", cyc, fifo_empty); else passed++;
      total++; if (fifo_full !== (q.size() == DEPTH)) $display("FAIL rnd_full cyc=%0d got=%0b", cyc, fifo_full); else passed++;
      if (q.size() > 0) begin
        total++; if (fifo_data !== q[0]) $display("FAIL rnd_head cyc=%0d got=%h exp=%h", cyc, fifo_data, q[0]); else passed++;
      end
      total++; if (overrun_cnt !== 8'(exp_ovr)) $display("FAIL rnd_ovr cyc=%0d got=%0d exp=%0d", cyc, overrun_cnt, exp_ovr); else passed++;
      total++; if (framing_cnt !== 8'(exp_frm)) $display("FAIL rnd_frm cyc=%0d got=%0d exp=%0d", cyc, framing_cnt, exp_frm); else passed++;

      dr  = ($urandom_range(0, 2) != 0);
      rxd = 8'($urandom);
      pp  = (cyc < 1000) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      oe  = ($urandom_range(0, 3) == 0);
      fe  = ($urandom_range(0, 5) == 0);
      ec  = ($urandom_range(0, 40) == 0);
      data_ready = dr; rx_data = rxd; pop = pp;
      overrun_error = oe; framing_error = fe; err_clear = ec;

      psh = dr && (q.size() < DEPTH) && seen_low;
      pok = pp && (q.size() > 0);
      if (pok) void'(q.pop_front());
      if (psh) q.push_back(rxd);
      exp_ack = psh;
      if (psh) begin
        seen_low = 1'b0;
        last_cap = cyc;
      end else if (!dr && cyc >= last_cap + 2) begin
        seen_low = 1'b1;
      end
      e_o = oe && !prev_oe;
      e_f = fe && !prev_fe;
      if (ec) begin
        exp_ovr = e_o ? 1 : 0;
        exp_frm = e_f ? 1 : 0;
      end else begin
        if (e_o && exp_ovr < 255) exp_ovr++;
        if (e_f && exp_frm < 255) exp_frm++;
      end
      prev_oe = oe;
      prev_fe = fe;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_single_byte();
    test_fill_stall_wrap();
    test_push_pop_same();
    test_err_counters();
    test_reset_in_ack();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
